mem_port_arbiter: RTL and testbench

//  Shares the single data-memory port between NREQ requesters: instruction fetch,

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between NREQ requesters (0 = fetch,
//   1 = load, 2 = store). Round-robin arbitration, one memory transaction at
//   a time. Drives the memory handshake (mem_start pulse, wait for mem_ready)
//   and returns read data plus a done pulse to the requester that won.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     defined   - a BUSY-cycle counter aborts the access after TIMEOUT cycles
//                 without mem_ready (done + err, rdata = all ones).
//     undefined - no counter, err tied low, BUSY waits on mem_ready forever.
//
// Ports
//   clk, reset          clock (posedge) and synchronous active-high reset
//   req[NREQ]           per-port request, held with addr/we/wdata until gnt
//   req_addr/we/wdata   per-port packed command fields, port i at [i*W +: W]
//   gnt[NREQ]           one-hot 1-cycle pulse: request accepted
//   done[NREQ]          one-hot 1-cycle pulse: transaction complete
//   rdata, err          read data / abort flag, valid with done, rdata held
//   busy                high while a transaction is owned
//   mem_start           1-cycle pulse starting a memory access
//   mem_addr/we/wdata   registered command, stable until mem_ready
//   mem_ready, mem_rdata memory completion and read data

module mem_port_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_start,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ready,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_PORT = IW'(NREQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, nextState;
  logic [IW-1:0] rrLast;     // most recent winner; scan starts just after it
  logic [IW-1:0] owner;      // port that owns the in-flight transaction
  logic [IW-1:0] winner;
  logic [IW-1:0] scanIdx;
  logic          anyReq;
  logic          grant;
  logic          memDone;
  logic          timedOut;

  // Round-robin pick: walk ports rrLast+1, rrLast+2, ... (mod NREQ) and take
  // the first one requesting.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    anyReq  = 1'b0;
    winner  = '0;
    scanIdx = rrLast;
    for (int k = 0; k < NREQ; k++) begin
      // NOTE: blocking assignments inside combinational logic, so scanIdx
      // advances within one evaluation; registers below use <= only.
      scanIdx = (scanIdx == LAST_PORT) ? '0 : scanIdx + 1'b1;
      if (!anyReq && req[scanIdx]) begin
        anyReq = 1'b1;
        winner = scanIdx;
      end
    end
  end

  assign grant = (state == IDLE) && anyReq;
  // A ready in the mem_start cycle is too early to belong to this access.
  assign memDone = (state == BUSY) && mem_ready && !mem_start;
  assign busy    = (state == BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] timer;

  // Counter is 0 in the mem_start cycle and equals k in BUSY cycle k, so the
  // abort's done lands TIMEOUT+1 cycles after mem_start.
  assign timedOut = (state == BUSY) && !memDone && (timer == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (state != BUSY) begin
      timer <= '0;
    end else if (!timedOut) begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign timedOut = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (anyReq) nextState = BUSY;
      BUSY:    if (memDone || timedOut) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset as well, because every output
      // here has a defined post-reset value; a reset mid-access simply drops it.
      gnt       <= '0;
      done      <= '0;
      mem_start <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata     <= '0;
      owner     <= '0;
      rrLast    <= LAST_PORT;
`ifdef MEM_TIMEOUT_EN
      err       <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      done      <= '0;
      mem_start <= 1'b0;

      if (grant) begin
        gnt[winner] <= 1'b1;
        mem_start   <= 1'b1;
        mem_addr    <= req_addr[int'(winner)*AW +: AW];
        mem_we      <= req_we[winner];
        mem_wdata   <= req_wdata[int'(winner)*DW +: DW];
        owner       <= winner;
        rrLast      <= winner;
      end

      if (memDone) begin
        done[owner] <= 1'b1;
        // A store returns nothing, so the last read value stays visible.
        if (!mem_we) rdata <= mem_rdata;
`ifdef MEM_TIMEOUT_EN
        err <= 1'b0;
`endif
      end

`ifdef MEM_TIMEOUT_EN
      if (timedOut) begin
        done[owner] <= 1'b1;
        err         <= 1'b1;
        rdata       <= '1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single-requester
// transactions, then hand-written sequences for rotation, late requests,
// reset mid-access and the timeout / no-timeout build.
module tb_mem_port_arbiter;

  localparam int NREQ    = 3;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              busy;
  logic              mem_start;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .mem_start (mem_start),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRd;
    int          lat;
    bit          early;
  } vec_t;

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t expQ[$];     // expected grants, in order
  exp_t flight[$];   // granted, waiting for done

  int checks = 0;
  int errors = 0;

  int memLat      = 1;   // cycles from mem_start to mem_ready; <0 = never
  bit earlyPulse  = 1'b0;
  bit strayPulse  = 1'b0;
  logic [15:0] memData [logic [15:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input int p, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] rd, input logic e);
    exp_t x;
    x.port = p; x.we = we; x.addr = addr; x.wdata = wd; x.rdata = rd; x.err = e;
    expQ.push_back(x);
  endtask

  task automatic setPort(input int p, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd);
    req_we[p]              = we;
    req_addr[p*AW +: AW]   = addr;
    req_wdata[p*DW +: DW]  = wd;
  endtask

  task automatic waitGnt(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (gnt == '0 && cyc < 64);
    check("gnt_seen", 32'(|gnt), 1);
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (done == '0 && cyc < 64);
    check("done_seen", 32'(|done), 1);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_gnt"},       gnt,       0);
    check({tag, "_done"},      done,      0);
    check({tag, "_err"},       err,       0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_mem_start"}, mem_start, 0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rdata"},     rdata,     0);
  endtask

  task automatic runVec(input vec_t v);
    int c;
    memLat     = v.lat;
    earlyPulse = v.early;
    pushExp(v.port, v.we, v.addr, v.wdata, v.expRd, 1'b0);
    setPort(v.port, v.we, v.addr, v.wdata);
    req = 3'b001 << v.port;
    waitGnt(c);
    check("gnt_latency", c, 1);
    req = '0;
    waitDone(c);
    check("done_latency", c, v.lat + 1);
    earlyPulse = 1'b0;
  endtask

  // Memory model: answers memLat cycles after mem_start; stores return junk
  // on mem_rdata so a store that overwrote rdata would be visible.
  initial begin : responder
    int cd;
    cd        = -1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (strayPulse) begin
        mem_ready  = 1'b1;
        mem_rdata  = 16'h7777;
        strayPulse = 1'b0;
      end
      if (mem_start === 1'b1) begin
        cd = memLat;
        if (earlyPulse) begin
          mem_ready = 1'b1;
          mem_rdata = 16'hDEAD;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            memData[mem_addr] = mem_wdata;
            mem_rdata         = 16'h5A5A;
          end else begin
            mem_rdata = memData.exists(mem_addr) ? memData[mem_addr] : 16'h0000;
          end
          cd = -1;
        end
      end
    end
  end

  // Scoreboard: pops an expected grant on every gnt, then the matching
  // expected completion on every done.
  initial begin : monitor
    exp_t       e;
    logic [2:0] oh;
    forever begin
      @(negedge clk);
      if (gnt != '0) begin
        if (expQ.size() == 0) begin
          check("unexpected_gnt", gnt, 0);
        end else begin
          e  = expQ.pop_front();
          oh = 3'b001 << e.port;
          check("gnt_port",    gnt,       oh);
          check("mem_start",   mem_start, 1);
          check("mem_addr",    mem_addr,  e.addr);
          check("mem_we",      mem_we,    e.we);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          check("busy_in_gnt", busy,      1);
          flight.push_back(e);
        end
      end else if (busy === 1'b1 && flight.size() != 0) begin
        check("addr_stable",  mem_addr,  flight[0].addr);
        check("we_stable",    mem_we,    flight[0].we);
        if (flight[0].we) check("wdata_stable", mem_wdata, flight[0].wdata);
        check("start_single", mem_start, 0);
      end
      if (done != '0) begin
        if (flight.size() == 0) begin
          check("stale_done", done, 0);
        end else begin
          e  = flight.pop_front();
          oh = 3'b001 << e.port;
          check("done_port",      done,  oh);
          check("rdata",          rdata, e.rdata);
          check("err",            err,   e.err);
          check("busy_with_done", busy,  0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[7];
    int   c;
    int   dn;

    reset     = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_we    = '0;
    req_wdata = '0;

    memData[16'h0040] = 16'hBEEF;
    memData[16'h0020] = 16'h0C0C;
    memData[16'h0100] = 16'h1111;
    memData[16'h0200] = 16'h2222;
    memData[16'h0300] = 16'h3333;

    //           port we    addr      wdata     expRd     lat early
    vecs[0] = '{1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2, 1'b0}; // basic load
    vecs[1] = '{2, 1'b1, 16'h0010, 16'h1234, 16'hBEEF, 3, 1'b0}; // store keeps rdata
    vecs[2] = '{1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1, 1'b0}; // read back, fastest
    vecs[3] = '{1, 1'b0, 16'h0020, 16'h0000, 16'h0C0C, 2, 1'b1}; // early ready ignored
    vecs[4] = '{0, 1'b1, 16'h0020, 16'hA55A, 16'h0C0C, 1, 1'b0};
    vecs[5] = '{0, 1'b0, 16'h0020, 16'h0000, 16'hA55A, 5, 1'b0};
    vecs[6] = '{2, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1, 1'b0}; // leaves rrLast = 2

    repeat (3) @(posedge clk);
    #1;
    checkReset("init");
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) runVec(vecs[i]);

    // All three requesting continuously: order 0,1,2,0 at one grant per 3 cycles.
    setPort(0, 1'b0, 16'h0100, 16'h0000);
    setPort(1, 1'b0, 16'h0200, 16'h0000);
    setPort(2, 1'b0, 16'h0300, 16'h0000);
    memLat = 1;
    pushExp(0, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1'b0);
    pushExp(1, 1'b0, 16'h0200, 16'h0000, 16'h2222, 1'b0);
    pushExp(2, 1'b0, 16'h0300, 16'h0000, 16'h3333, 1'b0);
    pushExp(0, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1'b0);
    req = 3'b111;
    waitGnt(c);
    check("rr_first_latency", c, 1);
    for (int k = 0; k < 3; k++) begin
      waitGnt(c);
      check("rr_gap", c, 3);
    end
    req = '0;
    waitDone(c);
    check("rr_last_done", c, 2);

    // req[0] rises while port 1 is busy; port 1 re-requests too. Rotation
    // from port 1 picks port 0 next, then port 1 again.
    memLat = 4;
    pushExp(1, 1'b0, 16'h0200, 16'h0000, 16'h2222, 1'b0);
    pushExp(0, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1'b0);
    pushExp(1, 1'b0, 16'h0200, 16'h0000, 16'h2222, 1'b0);
    req = 3'b010;
    waitGnt(c);
    check("solo_latency", c, 1);
    repeat (2) begin @(posedge clk); #1; end
    req = 3'b011;
    waitGnt(c);
    check("late_req_gnt", c, 4);
    req = 3'b010;
    waitGnt(c);
    check("requeue_gnt", c, 6);
    req = '0;
    waitDone(c);
    check("requeue_done", c, 5);

    // Reset one cycle into an access; the memory's later ready is stale.
    memLat = 3;
    pushExp(0, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1'b0);
    req = 3'b001;
    waitGnt(c);
    req = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    flight.delete();
    @(posedge clk); #1;
    checkReset("mid_txn");
    reset = 1'b0;
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done != '0) dn++;
    end
    check("stale_ready_no_done", dn, 0);

    // rrLast is back at NREQ-1, so port 0 beats port 1.
    memLat = 1;
    pushExp(0, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1'b0);
    req = 3'b011;
    waitGnt(c);
    check("post_reset_latency", c, 1);
    req = '0;
    waitDone(c);
    check("post_reset_done", c, 2);

    // Memory that never answers.
    memLat = -1;
    pushExp(2, 1'b0, 16'h0300, 16'h0000, 16'hFFFF, 1'b1);
    req = 3'b100;
    waitGnt(c);
    req = '0;
`ifdef MEM_TIMEOUT_EN
    waitDone(c);
    check("timeout_done_cycle", c, TIMEOUT + 1);
    strayPulse = 1'b1;
    dn = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done != '0) dn++;
    end
    check("stray_ready_no_done", dn, 0);
    check("rdata_after_stray",   rdata, 16'hFFFF);
    check("idle_after_abort",    busy,  0);
`else
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || done != '0) dn++;
    end
    check("busy_held_no_timeout", dn, 0);
    reset = 1'b1;
    flight.delete();
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    repeat (3) begin @(posedge clk); #1; end
    check("expq_drained",   expQ.size(),   0);
    check("flight_drained", flight.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
